// File: rtl/sfifo_flex.sv
// Parametrised single-clock FIFO over an inferred RAM with standard or first-word-fall-through read.
// Fill count, almost-full/almost-empty flags and overflow/underflow pulses are all registered.
module sfifo_flex #(
  parameter int C_DATA_WIDTH    = 64,
  parameter int C_ADDR_WIDTH    = 9,
  parameter int C_FWFT          = 0,
  parameter int C_AFULL_THRESH  = 2**C_ADDR_WIDTH - 4,
  parameter int C_AEMPTY_THRESH = 4
) (
  input  logic                    clk,
  input  logic                    arstn,
  input  logic [C_DATA_WIDTH-1:0] wdata,
  input  logic                    wren,
  output logic                    wfull,
  output logic                    walmost_full,
  output logic [C_DATA_WIDTH-1:0] rdata,
  input  logic                    rden,
  output logic                    rempty,
  output logic                    ralmost_empty,
  output logic [C_ADDR_WIDTH:0]   count,
  output logic                    overflow,
  output logic                    underflow
);

  localparam int DEPTH = 2**C_ADDR_WIDTH;
  localparam logic [C_ADDR_WIDTH:0]   DEPTH_C  = DEPTH[C_ADDR_WIDTH:0];
  localparam logic [C_ADDR_WIDTH:0]   AFULL_C  = C_AFULL_THRESH[C_ADDR_WIDTH:0];
  localparam logic [C_ADDR_WIDTH:0]   AEMPTY_C = C_AEMPTY_THRESH[C_ADDR_WIDTH:0];
  localparam logic [C_ADDR_WIDTH:0]   CNT_ONE  = {{C_ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [C_ADDR_WIDTH-1:0] PTR_ONE  = CNT_ONE[C_ADDR_WIDTH-1:0];

  logic [C_DATA_WIDTH-1:0] mem [DEPTH];
  logic [C_ADDR_WIDTH-1:0] wptr, rptr;
  logic                    live;
  logic                    head_valid;
  logic                    wr_acc, rd_acc, fetch, ram_rd;
  logic [C_ADDR_WIDTH:0]   count_nxt, ram_count;

  // In FWFT mode the head word sits in rdata, so the RAM holds count minus the head.
  always_comb begin
    wr_acc    = live && wren && !wfull;
    rd_acc    = live && rden && !rempty;
    count_nxt = count;
    unique case ({wr_acc, rd_acc})
      2'b10:   count_nxt = count + CNT_ONE;
      2'b01:   count_nxt = count - CNT_ONE;
      default: count_nxt = count;
    endcase
    ram_count = count - {{C_ADDR_WIDTH{1'b0}}, head_valid};
    fetch     = (C_FWFT != 0) && (ram_count != '0) && (!head_valid || rd_acc);
    ram_rd    = (C_FWFT != 0) ? fetch : rd_acc;
  end

  always_ff @(posedge clk) begin
    if (wr_acc) mem[wptr] <= wdata;
  end

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      live          <= 1'b0;
      wptr          <= '0;
      rptr          <= '0;
      head_valid    <= 1'b0;
      count         <= '0;
      rdata         <= '0;
      rempty        <= 1'b1;
      ralmost_empty <= 1'b1;
      wfull         <= 1'b0;
      walmost_full  <= 1'b0;
      overflow      <= 1'b0;
      underflow     <= 1'b0;
    end else begin
      live          <= 1'b1;
      overflow      <= live && wren && wfull;
      underflow     <= live && rden && rempty;
      count         <= count_nxt;
      wfull         <= (count_nxt == DEPTH_C);
      walmost_full  <= (count_nxt >= AFULL_C);
      ralmost_empty <= (count_nxt <= AEMPTY_C);
      if (wr_acc) wptr <= wptr + PTR_ONE;
      if (ram_rd) begin
        rptr  <= rptr + PTR_ONE;
        rdata <= mem[rptr];
      end
      if (C_FWFT != 0) begin
        if (fetch)       head_valid <= 1'b1;
        else if (rd_acc) head_valid <= 1'b0;
        rempty <= !(fetch || (head_valid && !rd_acc));
      end else begin
        rempty <= (count_nxt == '0);
      end
    end
  end

endmodule
